// File: rtl/md_unit.sv
// rtl/md_unit.sv - iterative RV32M multiply/divide stage; optional fast path under MD_UNIT_EARLY_OUT_EN
module md_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      target_reg,
    output logic            write_reg
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(XLEN);
    localparam logic [XLEN-1:0]   ONE      = XLEN'(1);
    localparam logic [2*XLEN-1:0] ONE2     = (2*XLEN)'(1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          op_q, op_d;
    logic [4:0]          rd_q, rd_d;
    logic [4:0]          target_q, target_d;
    logic [XLEN-1:0]     opnd_q, opnd_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic                neg_res_q, neg_res_d;
    logic                neg_rem_q, neg_rem_d;

    logic                in_a_sgn, in_b_sgn, in_b_zero;
    logic [XLEN-1:0]     in_a_mag, in_b_mag;

    always_comb begin
        in_a_sgn  = rs1_data[XLEN-1] & ((funct3 == 3'b001) | (funct3 == 3'b010) |
                                        (funct3 == 3'b100) | (funct3 == 3'b110));
        in_b_sgn  = rs2_data[XLEN-1] & ((funct3 == 3'b001) | (funct3 == 3'b100) |
                                        (funct3 == 3'b110));
        in_b_zero = (rs2_data == '0);
        in_a_mag  = in_a_sgn ? (~rs1_data + ONE) : rs1_data;
        in_b_mag  = in_b_sgn ? (~rs2_data + ONE) : rs2_data;
    end

    // acc low half holds the multiplier (mul) or dividend/quotient (div); opnd_q is multiplicand or divisor
    logic [XLEN:0]       mul_sum, div_shift, div_diff;
    logic                div_ge;
    logic [2*XLEN-1:0]   mul_next, div_next, prod_fin;
    logic [XLEN-1:0]     quo_fin, rem_fin, calc_result;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, opnd_q});
        div_diff  = div_shift - {1'b0, opnd_q};
        div_next  = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
        prod_fin  = neg_res_q ? (~acc_q + ONE2) : acc_q;
        quo_fin   = neg_res_q ? (~acc_q[XLEN-1:0] + ONE) : acc_q[XLEN-1:0];
        rem_fin   = neg_rem_q ? (~acc_q[2*XLEN-1:XLEN] + ONE) : acc_q[2*XLEN-1:XLEN];
        case (op_q)
            3'b000:                 calc_result = prod_fin[XLEN-1:0];
            3'b001, 3'b010, 3'b011: calc_result = prod_fin[2*XLEN-1:XLEN];
            3'b100, 3'b101:         calc_result = quo_fin;
            default:                calc_result = rem_fin;
        endcase
    end

`ifdef MD_UNIT_EARLY_OUT_EN
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic            eo_hit;
    logic [XLEN-1:0] eo_result;

    always_comb begin
        eo_hit    = 1'b0;
        eo_result = '0;
        if (funct3[2]) begin
            if (in_b_zero) begin
                eo_hit    = 1'b1;
                eo_result = funct3[1] ? rs1_data : '1;
            end else if (~funct3[0] && (rs1_data == MIN_NEG) && (rs2_data == '1)) begin
                eo_hit    = 1'b1;
                eo_result = funct3[1] ? '0 : MIN_NEG;
            end
        end else if ((rs1_data == '0) || in_b_zero) begin
            eo_hit    = 1'b1;
            eo_result = '0;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        rd_d      = rd_q;
        target_d  = target_q;
        opnd_d    = opnd_q;
        result_d  = result_q;
        acc_d     = acc_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d      = funct3;
                    rd_d      = rd_in;
                    cnt_d     = '0;
                    opnd_d    = funct3[2] ? in_b_mag : in_a_mag;
                    acc_d     = {{XLEN{1'b0}}, (funct3[2] ? in_a_mag : in_b_mag)};
                    // a zero divisor must yield all-ones quotient regardless of dividend sign
                    neg_res_d = (in_a_sgn ^ in_b_sgn) & ~(funct3[2] & in_b_zero);
                    neg_rem_d = in_a_sgn;
                    state_d   = S_CALC;
`ifdef MD_UNIT_EARLY_OUT_EN
                    if (eo_hit) begin
                        result_d = eo_result;
                        target_d = rd_in;
                        state_d  = S_DONE;
                    end
`endif
                end
            end
            S_CALC: begin
                if (cnt_q == CNT_LAST) begin
                    result_d = calc_result;
                    target_d = rd_q;
                    state_d  = S_DONE;
                end else begin
                    acc_d = op_q[2] ? div_next : mul_next;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            rd_q      <= '0;
            target_q  <= '0;
            opnd_q    <= '0;
            result_q  <= '0;
            acc_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            target_q  <= target_d;
            opnd_q    <= opnd_d;
            result_q  <= result_d;
            acc_q     <= acc_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    always_comb begin
        busy       = (state_q != S_IDLE);
        done       = (state_q == S_DONE);
        write_reg  = (state_q == S_DONE) && (target_q != 5'd0);
        result     = result_q;
        target_reg = target_q;
    end
endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - directed vector bench for md_unit, honours MD_UNIT_EARLY_OUT_EN
module tb_md_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_data, rs2_data;
    logic [4:0]  rd_in;
    logic        busy, done, write_reg;
    logic [31:0] result;
    logic [4:0]  target_reg;

    int checks = 0;
    int errors = 0;

`ifdef MD_UNIT_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    md_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_in(rd_in),
        .busy(busy), .done(done), .result(result),
        .target_reg(target_reg), .write_reg(write_reg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp_res;
        logic        exp_wr;
        logic        special;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v, input int idx);
        int k;
        logic busy_ok;
        logic [31:0] held;
        start    = 1'b1;
        funct3   = v.f3;
        rs1_data = v.a;
        rs2_data = v.b;
        rd_in    = v.rd;
        @(posedge clk); #1;
        k = 0;
        busy_ok = 1'b1;
        while (!done && k < 40) begin
            if (!busy) busy_ok = 1'b0;
            start    = 1'b1;
            funct3   = 3'($urandom);
            rs1_data = $urandom;
            rs2_data = $urandom;
            rd_in    = 5'($urandom);
            @(posedge clk); #1;
            k++;
        end
        start = 1'b0;
        chk($sformatf("latency[%0d]", idx), 64'(k), (EARLY && v.special) ? 64'd0 : 64'd33);
        chk($sformatf("busy_during[%0d]", idx), 64'(busy_ok), 64'd1);
        chk($sformatf("busy_at_done[%0d]", idx), 64'(busy), 64'd1);
        chk($sformatf("result[%0d]", idx), 64'(result), 64'(v.exp_res));
        chk($sformatf("target_reg[%0d]", idx), 64'(target_reg), 64'(v.rd));
        chk($sformatf("write_reg[%0d]", idx), 64'(write_reg), 64'(v.exp_wr));
        held = result;
        @(posedge clk); #1;
        chk($sformatf("after_done[%0d]", idx), {29'd0, done, write_reg, busy, held}, {35'd0, v.exp_res});
    endtask

    initial begin
        vecs[0]  = '{3'b000, 32'hFFFFFFFD, 32'd7,        5'd5,  32'hFFFFFFEB, 1'b1, 1'b0};
        vecs[1]  = '{3'b001, 32'hFFFFFFFD, 32'd7,        5'd5,  32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[2]  = '{3'b011, 32'hFFFFFFFD, 32'd7,        5'd5,  32'h00000006, 1'b1, 1'b0};
        vecs[3]  = '{3'b010, 32'hFFFFFFFD, 32'd7,        5'd9,  32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        5'd1,  32'hFFFFFFFD, 1'b1, 1'b0};
        vecs[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        5'd2,  32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[6]  = '{3'b101, 32'hFFFFFFF9, 32'd2,        5'd3,  32'h7FFFFFFC, 1'b1, 1'b0};
        vecs[7]  = '{3'b111, 32'hFFFFFFF9, 32'd2,        5'd4,  32'h00000001, 1'b1, 1'b0};
        vecs[8]  = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd6,  32'h80000000, 1'b1, 1'b1};
        vecs[9]  = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd7,  32'h00000000, 1'b1, 1'b1};
        vecs[10] = '{3'b101, 32'h00001234, 32'd0,        5'd8,  32'hFFFFFFFF, 1'b1, 1'b1};
        vecs[11] = '{3'b111, 32'h00001234, 32'd0,        5'd10, 32'h00001234, 1'b1, 1'b1};
        vecs[12] = '{3'b100, 32'h00001234, 32'd0,        5'd11, 32'hFFFFFFFF, 1'b1, 1'b1};
        vecs[13] = '{3'b110, 32'hFFFFFFF9, 32'd0,        5'd12, 32'hFFFFFFF9, 1'b1, 1'b1};
        vecs[14] = '{3'b000, 32'd3,        32'd4,        5'd0,  32'd12,       1'b0, 1'b0};
        vecs[15] = '{3'b001, 32'h80000000, 32'h80000000, 5'd31, 32'h40000000, 1'b1, 1'b0};
        vecs[16] = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd13, 32'hFFFFFFFE, 1'b1, 1'b0};
        vecs[17] = '{3'b100, 32'd100,      32'hFFFFFFF9, 5'd14, 32'hFFFFFFF2, 1'b1, 1'b0};

        rst = 1'b1; start = 1'b0; funct3 = 3'b000;
        rs1_data = '0; rs2_data = '0; rd_in = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset_idle[%0d]", i), {26'd0, busy, done, write_reg, target_reg, result},
                64'd0);
            @(posedge clk); #1;
        end

        for (int i = 0; i < 18; i++) run_op(vecs[i], i);

        begin
            int  k;
            logic seen;
            vec_t rv;
            rv = '{3'b110, 32'd100, 32'hFFFFFFF9, 5'd15, 32'd2, 1'b1, 1'b0};
            start = 1'b1; funct3 = 3'b100; rs1_data = 32'd1000; rs2_data = 32'd3; rd_in = 5'd20;
            @(posedge clk); #1;
            start = 1'b0;
            repeat (9) begin @(posedge clk); #1; end
            chk("busy_before_abort", 64'(busy), 64'd1);
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            chk("abort_state", {26'd0, busy, done, write_reg, target_reg, result}, 64'd0);
            seen = 1'b0;
            for (k = 0; k < 40; k++) begin
                if (done || write_reg || busy) seen = 1'b1;
                @(posedge clk); #1;
            end
            chk("no_pulse_after_abort", 64'(seen), 64'd0);
            run_op(rv, 99);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
